// File: rtl/camera_pkg.sv
// camera_pkg: shared state encoding, crop-window record and default geometry
// for the camera crop/capture path. Coordinates are 11-bit unsigned pixels.
// No logic of its own; imported by crop_window_calc and crop_window_controller.
package camera_pkg;

  localparam int COORD_W = 11;

  // Default sensor and crop geometry, overridable per instance.
  localparam int DEF_SENSOR_X_SIZE  = 1288;
  localparam int DEF_SQUARE_SIZE    = 720;
  localparam int DEF_Y_CROP_START   = 4;
  localparam int DEF_RESOLUTION     = 512;
  localparam int DEF_TIMEOUT_FRAMES = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    CAPTURING = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    coord_t x_start;
    coord_t x_end;
    coord_t y_start;
    coord_t y_end;
  } crop_window_t;

  // Centre a window of side res inside the pan-crop square.
  function automatic coord_t zoom_start(coord_t square, coord_t res);
    return (square - res) >> 1;
  endfunction

endpackage

// File: rtl/crop_window_calc.sv
// crop_window_calc: validates a crop request and computes pan/zoom windows.
// Latency: purely combinational (0 cycles); the parent registers the results.
// Backpressure: none; results are only meaningful while req_ok is high.
// Ports: x_pan (signed offset from centre), x_res/y_res (requested output
//   size) in; req_ok, pan_win, zoom_win out.
module crop_window_calc
  import camera_pkg::*;
#(
  parameter int SENSOR_X_SIZE = DEF_SENSOR_X_SIZE,
  parameter int SQUARE_SIZE   = DEF_SQUARE_SIZE,
  parameter int Y_CROP_START  = DEF_Y_CROP_START
) (
  input  logic signed [COORD_W-1:0] x_pan,
  input  coord_t                    x_res,
  input  coord_t                    y_res,
  output logic                      req_ok,
  output crop_window_t              pan_win,
  output crop_window_t              zoom_win
);

  // One extra bit so centre + offset cannot overflow before clamping.
  localparam int PAN_W = COORD_W + 1;
  localparam logic signed [PAN_W-1:0] PAN_CENTRE = PAN_W'((SENSOR_X_SIZE - SQUARE_SIZE) / 2);
  localparam logic signed [PAN_W-1:0] PAN_MAX    = PAN_W'(SENSOR_X_SIZE - SQUARE_SIZE);
  localparam coord_t SQ      = COORD_W'(SQUARE_SIZE);
  localparam coord_t Y0      = COORD_W'(Y_CROP_START);
  localparam coord_t MIN_RES = COORD_W'(16);

  // Encoder works on 16-pixel blocks, and the zoom must fit inside the square.
  function automatic logic res_valid(coord_t res);
    return (res[3:0] == 4'd0) && (res >= MIN_RES) && (res <= SQ);
  endfunction

  logic signed [PAN_W-1:0] pan_ext;
  logic signed [PAN_W-1:0] pan_sum;
  coord_t                  pan_clamped;

  always_comb begin
    pan_ext = {x_pan[COORD_W-1], x_pan};
    pan_sum = PAN_CENTRE + pan_ext;

    if (pan_sum[PAN_W-1]) begin
      pan_clamped = '0;
    end else if (pan_sum > PAN_MAX) begin
      pan_clamped = COORD_W'(PAN_MAX);
    end else begin
      pan_clamped = COORD_W'(pan_sum);
    end

    // Even start column keeps the Bayer phase of the cropped image intact.
    pan_win.x_start = pan_clamped & ~coord_t'(1);
    pan_win.x_end   = pan_win.x_start + SQ;
    pan_win.y_start = Y0;
    pan_win.y_end   = Y0 + SQ;

    zoom_win.x_start = zoom_start(SQ, x_res);
    zoom_win.x_end   = zoom_win.x_start + x_res;
    zoom_win.y_start = zoom_start(SQ, y_res);
    zoom_win.y_end   = zoom_win.y_start + y_res;

    req_ok = res_valid(x_res) && res_valid(y_res);
  end

endmodule

// File: rtl/crop_window_controller.sv
// crop_window_controller: frame-synchronous crop configuration and capture
//   sequencer. Optional capture timeout is built when CROP_CONTROLLER_TIMEOUT_EN
//   is defined; otherwise timeout_out is tied low and captures wait forever.
// Latency: boundary detected 1 cycle after frame_valid_in falls; windows and
//   sizes update the cycle after the boundary; start_capture_out follows one
//   cycle after that.
// Backpressure: none; config requests are last-writer-wins, capture requests
//   while ARMED/CAPTURING are dropped.
// Ports: frame_valid_in, config_update_in + x_pan_in/x_resolution_in/
//   y_resolution_in, start_capture_in, image_valid_in in; pan/zoom windows,
//   encoder sizes, start_capture_out, busy_out, config_error_out, timeout_out.
module crop_window_controller
  import camera_pkg::*;
#(
  parameter int SENSOR_X_SIZE      = DEF_SENSOR_X_SIZE,
  parameter int SQUARE_SIZE        = DEF_SQUARE_SIZE,
  parameter int Y_CROP_START       = DEF_Y_CROP_START,
  parameter int DEFAULT_RESOLUTION = DEF_RESOLUTION,
  parameter int TIMEOUT_FRAMES     = DEF_TIMEOUT_FRAMES
) (
  input  logic                      clock_in,
  input  logic                      reset_n_in,
  input  logic                      frame_valid_in,
  input  logic                      config_update_in,
  input  logic signed [COORD_W-1:0] x_pan_in,
  input  logic [COORD_W-1:0]        x_resolution_in,
  input  logic [COORD_W-1:0]        y_resolution_in,
  input  logic                      start_capture_in,
  input  logic                      image_valid_in,
  output logic [COORD_W-1:0]        pan_x_start_out,
  output logic [COORD_W-1:0]        pan_x_end_out,
  output logic [COORD_W-1:0]        pan_y_start_out,
  output logic [COORD_W-1:0]        pan_y_end_out,
  output logic [COORD_W-1:0]        zoom_x_start_out,
  output logic [COORD_W-1:0]        zoom_x_end_out,
  output logic [COORD_W-1:0]        zoom_y_start_out,
  output logic [COORD_W-1:0]        zoom_y_end_out,
  output logic [COORD_W-1:0]        x_size_out,
  output logic [COORD_W-1:0]        y_size_out,
  output logic                      start_capture_out,
  output logic                      busy_out,
  output logic                      config_error_out,
  output logic                      timeout_out
);

  if (TIMEOUT_FRAMES < 1) begin : g_bad_timeout
    $error("TIMEOUT_FRAMES must be at least 1");
  end

  localparam coord_t SQ   = COORD_W'(SQUARE_SIZE);
  localparam coord_t RES0 = COORD_W'(DEFAULT_RESOLUTION);
  localparam coord_t Y0   = COORD_W'(Y_CROP_START);
  localparam coord_t PAN0 = COORD_W'((SENSOR_X_SIZE - SQUARE_SIZE) / 2) & ~coord_t'(1);
  localparam coord_t Z0   = zoom_start(SQ, RES0);

  // Reset windows match a zero pan and the default output resolution.
  localparam crop_window_t RESET_PAN  = {PAN0, PAN0 + SQ, Y0, Y0 + SQ};
  localparam crop_window_t RESET_ZOOM = {Z0, Z0 + RES0, Z0, Z0 + RES0};

  logic         req_ok;
  crop_window_t calc_pan;
  crop_window_t calc_zoom;

  crop_window_calc #(
    .SENSOR_X_SIZE (SENSOR_X_SIZE),
    .SQUARE_SIZE   (SQUARE_SIZE),
    .Y_CROP_START  (Y_CROP_START)
  ) u_calc (
    .x_pan    (x_pan_in),
    .x_res    (x_resolution_in),
    .y_res    (y_resolution_in),
    .req_ok   (req_ok),
    .pan_win  (calc_pan),
    .zoom_win (calc_zoom)
  );

  ctrl_state_t  state;
  logic         fv_q;
  logic         bnd_q;
  logic         iv_q;
  logic         launch_q;
  logic         start_q;
  logic         busy_q;
  logic         err_q;
  crop_window_t pan_q;
  crop_window_t zoom_q;
  coord_t       xs_q;
  coord_t       ys_q;
  crop_window_t pend_pan;
  crop_window_t pend_zoom;
  coord_t       pend_xs;
  coord_t       pend_ys;
  logic         pend_vld;

  logic boundary;
  logic apply;
  logic iv_rise;

  // Falling edge of frame_valid, registered: high for one cycle after frame end.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      fv_q  <= 1'b0;
      bnd_q <= 1'b0;
      iv_q  <= 1'b0;
    end else begin
      fv_q  <= frame_valid_in;
      bnd_q <= fv_q & ~frame_valid_in;
      iv_q  <= image_valid_in;
    end
  end

  // Between frames an idle controller is always at a boundary, so requests
  // made there take effect without waiting for another frame.
  assign boundary = bnd_q | ((state == IDLE) & ~fv_q);
  assign apply    = boundary & pend_vld & (state != CAPTURING);
  assign iv_rise  = image_valid_in & ~iv_q;

  // Pending request and applied settings. An accept in the same cycle as an
  // apply leaves the new request pending for the next boundary.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pan_q     <= RESET_PAN;
      zoom_q    <= RESET_ZOOM;
      xs_q      <= RES0;
      ys_q      <= RES0;
      pend_pan  <= RESET_PAN;
      pend_zoom <= RESET_ZOOM;
      pend_xs   <= RES0;
      pend_ys   <= RES0;
      pend_vld  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (apply) begin
        pan_q    <= pend_pan;
        zoom_q   <= pend_zoom;
        xs_q     <= pend_xs;
        ys_q     <= pend_ys;
        pend_vld <= 1'b0;
      end
      if (config_update_in) begin
        if (req_ok) begin
          pend_pan  <= calc_pan;
          pend_zoom <= calc_zoom;
          pend_xs   <= x_resolution_in;
          pend_ys   <= y_resolution_in;
          pend_vld  <= 1'b1;
          err_q     <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

`ifdef CROP_CONTROLLER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_FRAMES - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;
`endif

  // Capture sequencer. In ARMED the boundary cycle applies config (above) and
  // sets launch_q; the encoder start fires on the following cycle so it always
  // sees the new sizes.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state    <= IDLE;
      launch_q <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef CROP_CONTROLLER_TIMEOUT_EN
      tmo_cnt  <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef CROP_CONTROLLER_TIMEOUT_EN
      if (start_capture_in) tmo_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          launch_q <= 1'b0;
          if (start_capture_in) state <= ARMED;
        end
        ARMED: begin
          if (launch_q) begin
            launch_q <= 1'b0;
            start_q  <= 1'b1;
            busy_q   <= 1'b1;
            state    <= CAPTURING;
`ifdef CROP_CONTROLLER_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end else if (bnd_q) begin
            launch_q <= 1'b1;
          end
        end
        CAPTURING: begin
          if (iv_rise) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
`ifdef CROP_CONTROLLER_TIMEOUT_EN
          else if (bnd_q) begin
            if (tmo_cnt == TMO_LAST) begin
              busy_q <= 1'b0;
              tmo_q  <= 1'b1;
              state  <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
`endif
        end
        default: begin
          launch_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef CROP_CONTROLLER_TIMEOUT_EN
  assign timeout_out = tmo_q;
`else
  assign timeout_out = 1'b0;
`endif

  assign pan_x_start_out   = pan_q.x_start;
  assign pan_x_end_out     = pan_q.x_end;
  assign pan_y_start_out   = pan_q.y_start;
  assign pan_y_end_out     = pan_q.y_end;
  assign zoom_x_start_out  = zoom_q.x_start;
  assign zoom_x_end_out    = zoom_q.x_end;
  assign zoom_y_start_out  = zoom_q.y_start;
  assign zoom_y_end_out    = zoom_q.y_end;
  assign x_size_out        = xs_q;
  assign y_size_out        = ys_q;
  assign start_capture_out = start_q;
  assign busy_out          = busy_q;
  assign config_error_out  = err_q;

endmodule

// File: tb/tb_crop_window_controller.sv
// Bench for crop_window_controller: table of directed requests, randomized
// requests against an arithmetic reference model, and hand-written capture,
// timeout and asynchronous-reset sequences.
module tb_crop_window_controller;

  logic        clock_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        frame_valid_in = 1'b0;
  logic        config_update_in = 1'b0;
  logic [10:0] x_pan_in = '0;
  logic [10:0] x_resolution_in = '0;
  logic [10:0] y_resolution_in = '0;
  logic        start_capture_in = 1'b0;
  logic        image_valid_in = 1'b0;
  logic [10:0] pan_x_start_out, pan_x_end_out, pan_y_start_out, pan_y_end_out;
  logic [10:0] zoom_x_start_out, zoom_x_end_out, zoom_y_start_out, zoom_y_end_out;
  logic [10:0] x_size_out, y_size_out;
  logic        start_capture_out, busy_out, config_error_out, timeout_out;

  crop_window_controller dut (
    .clock_in          (clock_in),
    .reset_n_in        (reset_n_in),
    .frame_valid_in    (frame_valid_in),
    .config_update_in  (config_update_in),
    .x_pan_in          (x_pan_in),
    .x_resolution_in   (x_resolution_in),
    .y_resolution_in   (y_resolution_in),
    .start_capture_in  (start_capture_in),
    .image_valid_in    (image_valid_in),
    .pan_x_start_out   (pan_x_start_out),
    .pan_x_end_out     (pan_x_end_out),
    .pan_y_start_out   (pan_y_start_out),
    .pan_y_end_out     (pan_y_end_out),
    .zoom_x_start_out  (zoom_x_start_out),
    .zoom_x_end_out    (zoom_x_end_out),
    .zoom_y_start_out  (zoom_y_start_out),
    .zoom_y_end_out    (zoom_y_end_out),
    .x_size_out        (x_size_out),
    .y_size_out        (y_size_out),
    .start_capture_out (start_capture_out),
    .busy_out          (busy_out),
    .config_error_out  (config_error_out),
    .timeout_out       (timeout_out)
  );

  always #5 clock_in = ~clock_in;

  int n_chk = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  always @(negedge clock_in) if (start_capture_out) pulse_cnt++;

  // ---------------- reference model ----------------
  typedef struct {
    int pxs, pxe, pys, pye, zxs, zxe, zys, zye, xs, ys;
  } win_t;

  win_t cur, pend;
  bit   pend_v;
  int   m_err;

  function automatic win_t m_calc(int pan, int xr, int yr);
    win_t w;
    int s;
    s = (1288 - 720) / 2 + pan;
    if (s < 0) s = 0;
    if (s > 1288 - 720) s = 1288 - 720;
    s = s - (s % 2);
    w.pxs = s;           w.pxe = s + 720;
    w.pys = 4;           w.pye = 4 + 720;
    w.zxs = (720 - xr) / 2; w.zxe = w.zxs + xr;
    w.zys = (720 - yr) / 2; w.zye = w.zys + yr;
    w.xs = xr;           w.ys = yr;
    return w;
  endfunction

  function automatic bit m_ok(int r);
    return (r % 16 == 0) && (r >= 16) && (r <= 720);
  endfunction

  task automatic m_request(input int pan, input int xr, input int yr);
    if (m_ok(xr) && m_ok(yr)) begin
      pend = m_calc(pan, xr, yr);
      pend_v = 1'b1;
      m_err = 0;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic m_apply();
    if (pend_v) cur = pend;
    pend_v = 1'b0;
  endtask

  task automatic m_reset();
    cur = m_calc(0, 512, 512);
    pend_v = 1'b0;
    m_err = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pan_x_start"}, pan_x_start_out, cur.pxs);
    chk({tag, ".pan_x_end"}, pan_x_end_out, cur.pxe);
    chk({tag, ".pan_y_start"}, pan_y_start_out, cur.pys);
    chk({tag, ".pan_y_end"}, pan_y_end_out, cur.pye);
    chk({tag, ".zoom_x_start"}, zoom_x_start_out, cur.zxs);
    chk({tag, ".zoom_x_end"}, zoom_x_end_out, cur.zxe);
    chk({tag, ".zoom_y_start"}, zoom_y_start_out, cur.zys);
    chk({tag, ".zoom_y_end"}, zoom_y_end_out, cur.zye);
    chk({tag, ".x_size"}, x_size_out, cur.xs);
    chk({tag, ".y_size"}, y_size_out, cur.ys);
    chk({tag, ".config_error"}, config_error_out, m_err);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic send_cfg(input int pan, input int xr, input int yr);
    x_pan_in = 11'(pan);
    x_resolution_in = 11'(xr);
    y_resolution_in = 11'(yr);
    config_update_in = 1'b1;
    step(1);
    config_update_in = 1'b0;
    m_request(pan, xr, yr);
  endtask

  task automatic frame(input int hi, input int lo);
    frame_valid_in = 1'b1;
    step(hi);
    frame_valid_in = 1'b0;
    step(lo);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int pan, xr, yr;
    int pxs, zxs, zxe, zys, zye, xs, ys, err;
  } vec_t;

  vec_t vecs[10];

  // Global time bound so a stuck run still reports.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, prev_xs;

    vecs[0] = '{400, 320, 240, 568, 200, 520, 240, 480, 320, 240, 0};
    vecs[1] = '{-301, 320, 240, 0, 200, 520, 240, 480, 320, 240, 0};
    vecs[2] = '{3, 320, 240, 286, 200, 520, 240, 480, 320, 240, 0};
    vecs[3] = '{0, 500, 512, 286, 200, 520, 240, 480, 320, 240, 1};
    vecs[4] = '{0, 256, 256, 284, 232, 488, 232, 488, 256, 256, 0};
    vecs[5] = '{1023, 720, 16, 568, 0, 720, 352, 368, 720, 16, 0};
    vecs[6] = '{-1024, 16, 720, 0, 352, 368, 0, 720, 16, 720, 0};
    vecs[7] = '{0, 0, 16, 0, 352, 368, 0, 720, 16, 720, 1};
    vecs[8] = '{50, 736, 16, 0, 352, 368, 0, 720, 16, 720, 1};
    vecs[9] = '{0, 512, 512, 284, 104, 616, 104, 616, 512, 512, 0};

    m_reset();

    // Reset state
    step(3);
    chk_all("reset");
    chk("reset.start_capture", start_capture_out, 0);
    chk("reset.busy", busy_out, 0);
    chk("reset.timeout", timeout_out, 0);
    reset_n_in = 1'b1;
    step(2);
    chk_all("post_reset");

    // Directed requests between frames (idle, frame_valid low)
    prev_xs = 512;
    for (int i = 0; i < 10; i++) begin
      send_cfg(vecs[i].pan, vecs[i].xr, vecs[i].yr);
      chk($sformatf("vec%0d.error", i), config_error_out, vecs[i].err);
      chk($sformatf("vec%0d.size_before_apply", i), x_size_out, prev_xs);
      step(1);
      m_apply();
      chk($sformatf("vec%0d.pan_x_start", i), pan_x_start_out, vecs[i].pxs);
      chk($sformatf("vec%0d.pan_x_end", i), pan_x_end_out, vecs[i].pxs + 720);
      chk($sformatf("vec%0d.pan_y_start", i), pan_y_start_out, 4);
      chk($sformatf("vec%0d.pan_y_end", i), pan_y_end_out, 724);
      chk($sformatf("vec%0d.zoom_x_start", i), zoom_x_start_out, vecs[i].zxs);
      chk($sformatf("vec%0d.zoom_x_end", i), zoom_x_end_out, vecs[i].zxe);
      chk($sformatf("vec%0d.zoom_y_start", i), zoom_y_start_out, vecs[i].zys);
      chk($sformatf("vec%0d.zoom_y_end", i), zoom_y_end_out, vecs[i].zye);
      chk($sformatf("vec%0d.x_size", i), x_size_out, vecs[i].xs);
      chk($sformatf("vec%0d.y_size", i), y_size_out, vecs[i].ys);
      prev_xs = vecs[i].xs;
    end

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      int pan, xr, yr;
      pan = int'($urandom_range(0, 2047)) - 1024;
      xr = ($urandom_range(0, 3) != 0) ? 16 * int'($urandom_range(1, 45)) : int'($urandom_range(0, 2047));
      yr = ($urandom_range(0, 3) != 0) ? 16 * int'($urandom_range(1, 45)) : int'($urandom_range(0, 2047));
      send_cfg(pan, xr, yr);
      step(1);
      m_apply();
      chk_all($sformatf("rand%0d", i));
    end

    // Capture: start mid-frame, pulse one cycle after the boundary
    p0 = pulse_cnt;
    frame_valid_in = 1'b1;
    step(2);
    start_capture_in = 1'b1;
    step(1);
    start_capture_in = 1'b0;
    step(3);
    chk("armed.busy", busy_out, 0);
    frame_valid_in = 1'b0;
    step(2);
    chk("capture.start_early", start_capture_out, 0);
    step(1);
    chk("capture.start_pulse", start_capture_out, 1);
    chk("capture.busy", busy_out, 1);
    step(1);
    chk("capture.start_one_cycle", start_capture_out, 0);

    // Config during capture is held; second start is ignored
    send_cfg(100, 640, 480);
    step(1);
    start_capture_in = 1'b1;
    step(1);
    start_capture_in = 1'b0;
    frame(4, 4);
    frame(4, 4);
    chk_all("capture.cfg_held");
    chk("capture.still_busy", busy_out, 1);
    chk("capture.single_pulse", pulse_cnt, p0 + 1);

    frame_valid_in = 1'b1;
    step(2);
    image_valid_in = 1'b1;
    step(1);
    image_valid_in = 1'b0;
    chk("image_valid.busy_clear", busy_out, 0);
    step(2);
    chk_all("image_valid.mid_frame");
    frame_valid_in = 1'b0;
    step(1);
    chk_all("image_valid.before_apply");
    step(1);
    m_apply();
    chk_all("image_valid.applied");
    chk("image_valid.pulse_total", pulse_cnt, p0 + 1);

    // Capture with no image_valid: timeout or indefinite wait
    p1 = pulse_cnt;
    start_capture_in = 1'b1;
    step(1);
    start_capture_in = 1'b0;
    frame(3, 4);
    chk("tmo.launch_pulse", pulse_cnt, p1 + 1);
    chk("tmo.busy_start", busy_out, 1);
    repeat (3) frame(3, 3);
    chk("tmo.busy_after_3", busy_out, 1);
    chk("tmo.timeout_after_3", timeout_out, 0);
    frame(3, 3);
`ifdef CROP_CONTROLLER_TIMEOUT_EN
    chk("tmo.timeout_after_4", timeout_out, 1);
    chk("tmo.busy_after_4", busy_out, 0);
    start_capture_in = 1'b1;
    step(1);
    start_capture_in = 1'b0;
    chk("tmo.cleared_by_start", timeout_out, 0);
`else
    chk("tmo.no_timeout_after_4", timeout_out, 0);
    chk("tmo.still_busy_after_4", busy_out, 1);
`endif

    // Rejected request, then asynchronous reset mid-cycle
    send_cfg(0, 100, 16);
    chk("bad_cfg.error", config_error_out, 1);
    #2;
    reset_n_in = 1'b0;
    #1;
    m_reset();
    chk_all("async_reset");
    chk("async_reset.busy", busy_out, 0);
    chk("async_reset.timeout", timeout_out, 0);
    chk("async_reset.start", start_capture_out, 0);
    step(1);
    reset_n_in = 1'b1;
    step(2);
    chk_all("after_async_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/crop_window_controller.md
Name: crop_window_controller

Overview:
- Frame-synchronous configuration and capture sequencer for the camera pipeline, in the pixel clock domain.
- Accepts pan, output-resolution and capture requests, already synchronised from the SPI domain.
- Validates each request, computes the pan-crop and zoom-crop windows, and drives the JPEG encoder size inputs.
- Applies new settings only at frame boundaries and never while an encode is in flight; gates start_capture so one capture maps to one whole frame.

Parameters:
- SENSOR_X_SIZE, 1288, active sensor columns.
- SQUARE_SIZE, 720, side of the pan-crop square.
- Y_CROP_START, 4, fixed pan-crop first row.
- DEFAULT_RESOLUTION, 512, output x/y size after reset.
- TIMEOUT_FRAMES, 4, frames allowed per capture (used only with the optional feature).

Ports:
- clock_in  in  1  pixel clock, 36 MHz
- reset_n_in  in  1  asynchronous, active-low reset
- frame_valid_in  in  1  frame valid from sensor byte_to_pixel stage
- config_update_in  in  1  single-cycle pulse; latch the three request fields below
- x_pan_in  in  11  signed pan offset from centre, in pixels
- x_resolution_in  in  11  requested output width
- y_resolution_in  in  11  requested output height
- start_capture_in  in  1  single-cycle capture request
- image_valid_in  in  1  encoder image_valid (image complete)
- pan_x_start_out, pan_x_end_out  out  11  pan-crop x window
- pan_y_start_out, pan_y_end_out  out  11  pan-crop y window
- zoom_x_start_out, zoom_x_end_out  out  11  zoom-crop x window
- zoom_y_start_out, zoom_y_end_out  out  11  zoom-crop y window
- x_size_out, y_size_out  out  11  encoder size
- start_capture_out  out  1  one-cycle pulse to encoder
- busy_out  out  1  capture in progress
- config_error_out  out  1  sticky until next accepted request
- timeout_out  out  1  sticky capture timeout (optional feature)

Behaviour:
Reset values:
- Windows correspond to pan 0 and DEFAULT_RESOLUTION: pan x 284..1004, pan y 4..724, zoom 104..616 in both axes.
- x_size_out = y_size_out = 512.
- All flags and pulses 0; state IDLE; no pending request.

Frame boundary:
- A boundary is the cycle after frame_valid_in falls (registered edge detect, 1-cycle latency).
- frame_valid_in low in IDLE also counts as a boundary, so a request made between frames applies at once.

Validation (at config_update_in):
- A request is accepted only if both resolutions are multiples of 16 and lie in 16..SQUARE_SIZE.
- An accepted request overwrites any pending request (last writer wins) and clears config_error_out.
- A rejected request sets config_error_out and leaves the pending request untouched.

Arithmetic (unsigned 11-bit results, signed 12-bit intermediate):
- pan_x_start = clamp(((SENSOR_X_SIZE-SQUARE_SIZE)/2) + x_pan, 0, SENSOR_X_SIZE-SQUARE_SIZE), then LSB cleared to keep Bayer phase.
- pan_x_end = pan_x_start + SQUARE_SIZE.
- pan_y_start = Y_CROP_START; pan_y_end = Y_CROP_START + SQUARE_SIZE.
- zoom_start = (SQUARE_SIZE - res) >> 1 per axis; zoom_end = zoom_start + res.
- x_size_out/y_size_out equal the resolutions.

Apply:
- A pending request is applied at a boundary in IDLE or ARMED, never in CAPTURING.
- All window and size outputs update together on the cycle after the boundary.

State machine:
- IDLE: start_capture_in goes to ARMED.
- ARMED: at a boundary, apply any pending request first. One cycle later, pulse start_capture_out and go to CAPTURING.
- CAPTURING: busy_out=1. image_valid_in rising goes to IDLE; the first boundary after that may apply pending config.
- start_capture_in while ARMED or CAPTURING is ignored, with no queueing.
- config_update_in and start_capture_in in the same cycle: both are registered; the config applies before the capture.
- Mid-operation reset returns everything to the reset values immediately.

Optional Feature:
- Macro: CROP_CONTROLLER_TIMEOUT_EN.
- Enabled: CAPTURING counts boundaries. After TIMEOUT_FRAMES boundaries with no image_valid_in, the FSM goes to IDLE and sets timeout_out until the next start_capture_in.
- Disabled: no counter is built; timeout_out is tied to 0; CAPTURING waits indefinitely.

Decomposition:
- Package camera_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURING);
  - SENSOR_X_SIZE, SQUARE_SIZE and Y_CROP_START default constants;
  - a packed crop_window_t struct {x_start, x_end, y_start, y_end}, 11 bits each.
- One sub-module, crop_window_calc: purely combinational validation plus window arithmetic, instantiated once, outputs registered in the parent.

Test Plan:
- Reset with no activity -> pan x 284/1004, pan y 4/724, zoom 104/616 both axes, size 512x512, all flags 0.
- Request pan +400, res 320x240, frame_valid low -> pan x 568/1288, zoom x 200/520, zoom y 240/480, size 320x240, one cycle after apply.
- Request pan -301 -> pan x start 0; pan +3 -> pan x start 286 (LSB cleared).
- Request res 500x512 -> config_error_out=1, outputs unchanged; then res 256x256 -> error clears and zoom 232/488 applies at the next boundary.
- start_capture_in mid-frame, then a config request during CAPTURING -> start_capture_out pulses once, one cycle after the frame end. The new config applies at the first boundary after image_valid_in, not before. A second start_capture_in while busy produces no pulse.
- With CROP_CONTROLLER_TIMEOUT_EN and image_valid_in held low -> after 4 frame ends timeout_out=1, busy_out=0, state IDLE. Next start_capture_in clears timeout_out.
